// File: rtl/param_updown_counter_pkg.sv
// Shared definitions for the up/down counter family: bound-mode constants and
// the prescaler width helper.
package counter_pkg;

   localparam int CNT_WRAP = 0;
   localparam int CNT_SAT  = 1;

   // A divide-by-1 prescaler still needs one bit so the phase register is never zero-width.
   function automatic int presc_width(input int presc);
      int w;
      w = $clog2(presc);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control/status bundle of the up/down counter: the master drives the controls
// and observes the registered status.
interface param_updown_counter_if #(
   parameter int WIDTH = 8
);
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             is_up;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output clr, load, load_val, en, is_up, limit,
      input  count, tc, ovf
   );

   modport slave (
      input  clr, load, load_val, en, is_up, limit,
      output count, tc, ovf
   );
endinterface

// File: rtl/param_updown_counter_prescaler.sv
// Enable divider: the phase runs 0..PRESCALE-1 while en is high, and tick marks
// the last phase. A low en freezes the phase without resetting it.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= (phase == LAST) ? '0 : phase + 1'b1;
      end
   end

   // With PRESCALE=1 the phase stays at 0 == LAST, so tick follows en directly.
   assign tick = en && (phase == LAST);

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with runtime limit, wrap/saturate bounds,
// clear/load, prescaled enable, terminal-count pulse and sticky overflow.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   param_updown_counter_if.slave  bus
);

   localparam bit SAT = (SATURATE == CNT_SAT);

   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             ovf_q;
   logic             tick;

   // Load also restarts the prescale period, so the prescaler sees clr|load.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk  (clk),
      .rstn (rstn),
      .clr  (bus.clr | bus.load),
      .en   (bus.en),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.clr) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (bus.load) begin
         count_q <= bus.load_val;
         tc_q    <= 1'b0;
      end else if (tick) begin
         if (bus.is_up) begin
            // Counts above a lowered limit are treated as having hit the bound.
            if (count_q >= bus.limit) begin
               count_q <= SAT ? bus.limit : '0;
               tc_q    <= 1'b1;
               ovf_q   <= 1'b1;
            end else begin
               count_q <= count_q + 1'b1;
               tc_q    <= 1'b0;
            end
         end else begin
            if (count_q == '0) begin
               count_q <= SAT ? '0 : bus.limit;
               tc_q    <= 1'b1;
               ovf_q   <= 1'b1;
            end else begin
               count_q <= count_q - 1'b1;
               tc_q    <= 1'b0;
            end
         end
      end else begin
         tc_q <= 1'b0;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: three instances cover the default
// wrap build, a saturating build and a divide-by-4 prescaled build.
`timescale 1ns/1ps
module tb_param_updown_counter;

   logic clk;
   logic rstn;

   int n_tests;
   int n_fail;

   param_updown_counter_if #(.WIDTH(8)) ifa ();
   param_updown_counter_if #(.WIDTH(8)) ifs ();
   param_updown_counter_if #(.WIDTH(8)) ifp ();

   param_updown_counter #(.WIDTH(8), .SATURATE(0), .PRESCALE(1)) dut_a (
      .clk (clk), .rstn (rstn), .bus (ifa)
   );
   param_updown_counter #(.WIDTH(8), .SATURATE(1), .PRESCALE(1)) dut_s (
      .clk (clk), .rstn (rstn), .bus (ifs)
   );
   param_updown_counter #(.WIDTH(8), .SATURATE(0), .PRESCALE(4)) dut_p (
      .clk (clk), .rstn (rstn), .bus (ifp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rstn = 1'b0;
      ifa.clr = 0; ifa.load = 0; ifa.load_val = 0; ifa.en = 1; ifa.is_up = 1; ifa.limit = 8'd255;
      ifs.clr = 0; ifs.load = 0; ifs.load_val = 0; ifs.en = 0; ifs.is_up = 1; ifs.limit = 8'd5;
      ifp.clr = 0; ifp.load = 0; ifp.load_val = 0; ifp.en = 0; ifp.is_up = 1; ifp.limit = 8'd255;

      // reset and basic counting
      #8;
      check("rst_count", ifa.count, 0);
      check("rst_tc", ifa.tc, 0);
      check("rst_ovf", ifa.ovf, 0);
      #2 rstn = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         cyc();
         check("basic_up", ifa.count, i);
         check("basic_up_tc", ifa.tc, 0);
      end
      ifa.is_up = 0;
      for (int i = 2; i >= 0; i--) begin
         cyc();
         check("basic_down", ifa.count, i);
      end
      cyc();
      check("basic_wrap_count", ifa.count, 255);
      check("basic_wrap_tc", ifa.tc, 1);
      check("basic_wrap_ovf", ifa.ovf, 1);
      cyc();
      check("basic_after_count", ifa.count, 254);
      check("basic_after_tc", ifa.tc, 0);
      check("basic_after_ovf", ifa.ovf, 1);

      // wrap with limit 5
      ifa.clr = 1;
      cyc();
      check("clr_count", ifa.count, 0);
      check("clr_ovf", ifa.ovf, 0);
      ifa.clr = 0; ifa.limit = 8'd5; ifa.is_up = 1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         check("wrap_up", ifa.count, i);
         check("wrap_up_tc", ifa.tc, 0);
      end
      cyc();
      check("wrap_5to0", ifa.count, 0);
      check("wrap_5to0_tc", ifa.tc, 1);
      check("wrap_5to0_ovf", ifa.ovf, 1);
      ifa.is_up = 0;
      cyc();
      check("wrap_0to5", ifa.count, 5);
      check("wrap_0to5_tc", ifa.tc, 1);
      cyc();
      check("wrap_dn4", ifa.count, 4);
      check("wrap_dn4_tc", ifa.tc, 0);

      // priority and out-of-range load
      ifa.clr = 1; ifa.load = 1; ifa.load_val = 8'd77;
      cyc();
      check("prio_clr", ifa.count, 0);
      check("prio_clr_ovf", ifa.ovf, 0);
      ifa.clr = 0; ifa.load_val = 8'd200; ifa.limit = 8'd100; ifa.is_up = 1;
      cyc();
      check("load_200", ifa.count, 200);
      check("load_tc", ifa.tc, 0);
      ifa.load = 0;
      cyc();
      check("above_limit_up", ifa.count, 0);
      check("above_limit_tc", ifa.tc, 1);
      ifa.load = 1; ifa.is_up = 0;
      cyc();
      check("load_200_dn", ifa.count, 200);
      ifa.load = 0;
      cyc();
      check("above_limit_dn", ifa.count, 199);
      check("above_limit_dn_tc", ifa.tc, 0);
      ifa.en = 0;

      // saturate build
      ifs.en = 1; ifs.is_up = 1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         check("sat_up", ifs.count, i);
      end
      cyc();
      check("sat_hold", ifs.count, 5);
      check("sat_hold_tc", ifs.tc, 1);
      check("sat_hold_ovf", ifs.ovf, 1);
      cyc();
      check("sat_hold2", ifs.count, 5);
      check("sat_hold2_tc", ifs.tc, 1);
      ifs.clr = 1;
      cyc();
      check("sat_clr", ifs.count, 0);
      check("sat_clr_ovf", ifs.ovf, 0);
      check("sat_clr_tc", ifs.tc, 0);
      ifs.clr = 0; ifs.is_up = 0;
      cyc();
      check("sat_low", ifs.count, 0);
      check("sat_low_tc", ifs.tc, 1);
      ifs.en = 0;

      // prescaler: step every 4th enabled clock, phase kept across en=0
      ifp.en = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("presc_wait", ifp.count, 0);
      end
      cyc();
      check("presc_step1", ifp.count, 1);
      cyc();
      cyc();
      check("presc_mid", ifp.count, 1);
      ifp.en = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("presc_frozen", ifp.count, 1);
      end
      ifp.en = 1;
      cyc();
      check("presc_resume", ifp.count, 1);
      cyc();
      check("presc_step2", ifp.count, 2);
      check("presc_step2_tc", ifp.tc, 0);
      ifp.en = 0;

      // async reset mid-count
      ifa.clr = 1; ifa.limit = 8'd255; ifa.en = 1;
      cyc();
      ifa.clr = 0; ifa.is_up = 0;
      cyc();
      check("ar_pre_wrap", ifa.count, 255);
      ifa.is_up = 1;
      cyc();
      check("ar_pre_zero", ifa.count, 0);
      for (int i = 1; i <= 7; i++) cyc();
      check("ar_count7", ifa.count, 7);
      check("ar_ovf_set", ifa.ovf, 1);
      #2 rstn = 1'b0;
      #1;
      check("ar_count", ifa.count, 0);
      check("ar_tc", ifa.tc, 0);
      check("ar_ovf", ifa.ovf, 0);
      cyc();
      check("ar_held", ifa.count, 0);
      #2 rstn = 1'b1;
      cyc();
      check("ar_resume1", ifa.count, 1);
      cyc();
      check("ar_resume2", ifa.count, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
